// File: rtl/param_delay_line_if.sv
// Bundled control/data/status signals of param_delay_line.
// The master drives En/Mode/D; the slave returns the delay-line status outputs.
interface param_delay_line_if #(
    parameter int WIDTH = 8
) ();
    // No handshake: D is sampled on every rising Clk edge where En=1 and Mode
    // selects shift or load. Valid is a level status (line full), never a request.
    logic             En;
    logic [1:0]       Mode;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [4:0]       Count;
    logic             Valid;
    logic [WIDTH-1:0] Rise;
    logic [WIDTH-1:0] Fall;

    modport master (
        output En, Mode, D,
        input  Q, Count, Valid, Rise, Fall
    );

    modport slave (
        input  En, Mode, D,
        output Q, Count, Valid, Rise, Fall
    );
endinterface

// File: rtl/param_delay_line.sv
// Parameterised shift/load/clear delay line with a saturating fill counter.
// Optional Q edge detector enabled by macro PARAM_DELAY_LINE_EDGE_DETECT_EN.
module param_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    param_delay_line_if.slave   bus
);
    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;
    localparam logic [4:0] FULL       = 5'(DEPTH);

    logic [WIDTH-1:0] s [DEPTH];
    logic [4:0]       count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) s[i] <= '0;
            count <= '0;
        end else if (bus.En) begin
            case (bus.Mode)
                MODE_SHIFT: begin
                    s[0] <= bus.D;
                    for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
                    // The fill counter saturates; the oldest stage simply falls off.
                    if (count != FULL) count <= count + 5'd1;
                end
                MODE_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) s[i] <= bus.D;
                    count <= FULL;
                end
                MODE_CLEAR: begin
                    for (int i = 0; i < DEPTH; i++) s[i] <= '0;
                    count <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.Q     = s[DEPTH-1];
    assign bus.Count = count;
    assign bus.Valid = (count == FULL);

`ifdef PARAM_DELAY_LINE_EDGE_DETECT_EN
    logic [WIDTH-1:0] qp;

    // History tracks Q every edge regardless of En so Rise/Fall last one cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                                  qp <= '0;
        else if (bus.En && bus.Mode == MODE_CLEAR)  qp <= '0;
        else                                        qp <= s[DEPTH-1];
    end

    assign bus.Rise = s[DEPTH-1] & ~qp;
    assign bus.Fall = ~s[DEPTH-1] & qp;
`else
    assign bus.Rise = '0;
    assign bus.Fall = '0;
`endif
endmodule
